// File: rtl/mag_cmp_pipe.sv
// mag_cmp_pipe
// Two-stage pipelined magnitude comparator. One of N_CH packed channel
// operands (A) is compared against a threshold (B) in one of four modes.
// The result and the originating channel index come out two cycles after
// the beat is accepted.
//
// Stage S1 registers the selected operand, threshold, carry, mode and
// channel. Stage S2 registers the compare result and channel, and drives
// the outputs. Both stages advance together whenever the output register
// is empty or being drained. This means a stall at the output freezes the
// whole pipe.
//
// Parameters
//   W          operand width (2..32)
//   N_CH       number of channels, power of two (2..16)
//   SIGNED_CMP 1 = two's-complement compare, 0 = unsigned compare
//
// Ports
//   clk        clock, all flops on posedge
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   block accepts the beat this cycle
//   ch_data    packed operands, channel k at [k*W +: W]
//   ch_sel     selects operand A
//   thr        threshold operand B
//   cin        tie-break carry, used only in GT mode
//   cmp_mode   00 GT, 01 GE, 10 LT, 11 EQ
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   out_hit    compare result
//   out_ch     ch_sel of the beat that produced the result
//   hit_cnt    saturating count of delivered hits
//
// Build option
//   MAG_CMP_HIT_CNT_EN  when defined, hit_cnt counts delivered hits and
//                       saturates at 255. When undefined, hit_cnt is tied
//                       to zero and no counter flops exist.

module mag_cmp_pipe #(
    parameter int W          = 8,
    parameter int N_CH       = 4,
    parameter int SIGNED_CMP = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH*W-1:0]       ch_data,
    input  logic [$clog2(N_CH)-1:0] ch_sel,
    input  logic [W-1:0]            thr,
    input  logic                    cin,
    input  logic [1:0]              cmp_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_hit,
    output logic [$clog2(N_CH)-1:0] out_ch,
    output logic [7:0]              hit_cnt
);

    localparam int SEL_W = $clog2(N_CH);

    typedef enum logic [1:0] {
        MODE_GT = 2'b00,
        MODE_GE = 2'b01,
        MODE_LT = 2'b10,
        MODE_EQ = 2'b11
    } cmp_mode_t;

    // Stage 1 registers
    logic             s1_valid;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic             s1_cin;
    cmp_mode_t        s1_mode;
    logic [SEL_W-1:0] s1_ch;

    // Stage 2 registers (these drive the outputs directly)
    logic             s2_valid;
    logic             s2_hit;
    logic [SEL_W-1:0] s2_ch;

    logic             en;
    logic [W-1:0]     a_sel;
    logic             a_gt;
    logic             a_eq;
    logic             hit_next;

    // A single advance enable keeps both stages in lock-step. Holding S1
    // while S2 is stalled is what prevents beats from being lost.
    assign en       = !s2_valid || out_ready;
    assign in_ready = en;

    // Operand mux. A compare loop is used instead of a variable part-select
    // so that all index widths stay exact. Because N_CH is a power of two,
    // every ch_sel value maps to a real channel.
    always_comb begin
        a_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_sel == SEL_W'(k)) begin
                a_sel = ch_data[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_mode  <= MODE_GT;
            s1_ch    <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_a     <= a_sel;
            s1_b     <= thr;
            s1_cin   <= cin;
            s1_mode  <= cmp_mode_t'(cmp_mode);
            s1_ch    <= ch_sel;
        end
    end

    // Greater-than and equality are the only primitives needed. The other
    // modes are derived from these two, so signedness is decided once here.
    always_comb begin
        a_eq = (s1_a == s1_b);
        if (SIGNED_CMP != 0) begin
            a_gt = ($signed(s1_a) > $signed(s1_b));
        end else begin
            a_gt = (s1_a > s1_b);
        end
    end

    always_comb begin
        hit_next = 1'b0;
        unique case (s1_mode)
            MODE_GT: hit_next = a_gt || (a_eq && s1_cin);
            MODE_GE: hit_next = a_gt || a_eq;
            MODE_LT: hit_next = !a_gt && !a_eq;
            MODE_EQ: hit_next = a_eq;
            default: hit_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_hit   <= 1'b0;
            s2_ch    <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_hit   <= hit_next;
            s2_ch    <= s1_ch;
        end
    end

    assign out_valid = s2_valid;
    assign out_hit   = s2_hit;
    assign out_ch    = s2_ch;

`ifdef MAG_CMP_HIT_CNT_EN
    logic [7:0] hit_cnt_q;

    // Count only hits that are actually handed downstream, so a stalled
    // result is not counted more than once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= 8'd0;
        end else if (s2_valid && out_ready && s2_hit && (hit_cnt_q != 8'hFF)) begin
            hit_cnt_q <= hit_cnt_q + 8'd1;
        end
    end

    assign hit_cnt = hit_cnt_q;
`else
    assign hit_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mag_cmp_pipe.sv
// tb_mag_cmp_pipe
// Self-checking bench for mag_cmp_pipe. It drives an unsigned instance and
// a signed instance from the same stimulus. Every accepted beat pushes its
// expected results onto a scoreboard queue. A monitor pops the queue on
// each delivered result. Scenario tasks add their own inline checks for
// latency, stall stability, reset behaviour and the hit counter.

module tb_mag_cmp_pipe;

    localparam int W    = 8;
    localparam int N_CH = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [31:0] ch_data   = '0;
    logic [1:0]  ch_sel    = '0;
    logic [7:0]  thr       = '0;
    logic        cin       = 1'b0;
    logic [1:0]  cmp_mode  = '0;
    logic        out_ready = 1'b1;

    logic        in_ready,  in_ready_s;
    logic        out_valid, out_valid_s;
    logic        out_hit,   out_hit_s;
    logic [1:0]  out_ch,    out_ch_s;
    logic [7:0]  hit_cnt,   hit_cnt_s;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       hit_u;
        logic       hit_s;
        logic [1:0] ch;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] mon_a;

`ifdef MAG_CMP_HIT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    mag_cmp_pipe #(.W(W), .N_CH(N_CH), .SIGNED_CMP(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ch_data(ch_data), .ch_sel(ch_sel), .thr(thr), .cin(cin),
        .cmp_mode(cmp_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_ch(out_ch), .hit_cnt(hit_cnt)
    );

    mag_cmp_pipe #(.W(W), .N_CH(N_CH), .SIGNED_CMP(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .ch_data(ch_data), .ch_sel(ch_sel), .thr(thr), .cin(cin),
        .cmp_mode(cmp_mode), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_hit(out_hit_s), .out_ch(out_ch_s), .hit_cnt(hit_cnt_s)
    );

    always #5 clk = ~clk;

    // Reference compare written straight from the mode definitions
    function automatic logic model_hit(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic [1:0] m,
                                       input bit sgn);
        logic gt;
        logic eq;
        eq = (a == b);
        gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
        case (m)
            2'b00:   return gt || (eq && c);
            2'b01:   return gt || eq;
            2'b10:   return !gt && !eq;
            default: return eq;
        endcase
    endfunction

    // Monitor samples on the falling edge. Inputs change just after the
    // rising edge, so the handshakes seen here are the ones the next rising
    // edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL sb_unexpected: result hit=%0b ch=%0d delivered with empty scoreboard", out_hit, out_ch);
                end else begin
                    mon_e = sb.pop_front();
                    if (out_hit !== mon_e.hit_u || out_ch !== mon_e.ch) begin
                        n_fail++;
                        $display("[TB] FAIL sb_unsigned: got hit=%0b ch=%0d, expected hit=%0b ch=%0d", out_hit, out_ch, mon_e.hit_u, mon_e.ch);
                    end
                    n_cmp++;
                    if (out_valid_s !== 1'b1 || out_hit_s !== mon_e.hit_s || out_ch_s !== mon_e.ch) begin
                        n_fail++;
                        $display("[TB] FAIL sb_signed: got valid=%0b hit=%0b ch=%0d, expected valid=1 hit=%0b ch=%0d", out_valid_s, out_hit_s, out_ch_s, mon_e.hit_s, mon_e.ch);
                    end
                end
            end
            if (in_valid && in_ready) begin
                mon_a = 8'(ch_data >> (8 * ch_sel));
                sb.push_back('{hit_u: model_hit(mon_a, thr, cin, cmp_mode, 1'b0),
                               hit_s: model_hit(mon_a, thr, cin, cmp_mode, 1'b1),
                               ch:    ch_sel});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [1:0] sel,
                                 input logic [7:0] b, input logic c,
                                 input logic [1:0] mode);
        ch_data  = data;
        ch_sel   = sel;
        thr      = b;
        cin      = c;
        cmp_mode = mode;
        in_valid = 1'b1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_hit !== 1'b0 || out_ch !== 2'd0 || hit_cnt !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got valid=%0b hit=%0b ch=%0d cnt=%0d, expected all zero", out_valid, out_hit, out_ch, hit_cnt);
        end
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready);
        end
    endtask

    task automatic test_gt_tiebreak();
        int k;
        do_reset();
        out_ready = 1'b1;
        applyStimulus(32'h0040_0000, 2'd2, 8'h40, 1'b1, 2'b00);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL gt_latency_early: out_valid=%0b one cycle after accept, expected 0", out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_hit !== 1'b1 || out_ch !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL gt_cin1: got valid=%0b hit=%0b ch=%0d, expected valid=1 hit=1 ch=2", out_valid, out_hit, out_ch);
        end
        applyStimulus(32'h0040_0000, 2'd2, 8'h40, 1'b0, 2'b00);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_hit !== 1'b0 || out_ch !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL gt_cin0: got valid=%0b hit=%0b ch=%0d, expected valid=1 hit=0 ch=2", out_valid, out_hit, out_ch);
        end
        k = 0;
        while (sb.size() != 0 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL gt_drain: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_signed();
        int k;
        do_reset();
        out_ready = 1'b1;
        applyStimulus(32'h0000_0080, 2'd0, 8'h01, 1'b0, 2'b10);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_hit !== 1'b0 || out_hit_s !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL signed_lt: got unsigned hit=%0b signed hit=%0b, expected 0 and 1", out_hit, out_hit_s);
        end
        k = 0;
        while (sb.size() != 0 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL signed_drain: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_random();
        int k;
        logic [1:0] sel;
        logic [31:0] data;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            data = $urandom;
            sel  = 2'($urandom_range(0, 3));
            applyStimulus(data, sel, 8'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) thr = 8'(data >> (8 * sel));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL random_drain: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int k;
        logic stable_ok;
        do_reset();
        out_ready = 1'b0;
        applyStimulus(32'h0500_1030, 2'd1, 8'h20, 1'b0, 2'b10);
        tick();
        applyStimulus(32'h0500_1030, 2'd3, 8'h06, 1'b0, 2'b11);
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_full_ready: got in_ready=%0b expected 0", in_ready);
        end
        applyStimulus(32'h0500_1030, 2'd0, 8'h30, 1'b0, 2'b01);
        stable_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_hit !== 1'b1 || out_ch !== 2'd1) begin
                stable_ok = 1'b0;
                $display("[TB] FAIL bp_stall_cycle%0d: got ready=%0b valid=%0b hit=%0b ch=%0d, expected 0 1 1 1", i, in_ready, out_valid, out_hit, out_ch);
            end
        end
        n_cmp++;
        if (!stable_ok) n_fail++;
        n_cmp++;
        if (sb.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL bp_held_beats: %0d beats held, expected 2", sb.size());
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (sb.size() != 0 && k < 20) begin tick(); k++; end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL bp_drain: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_stream();
        int run;
        int best;
        int total;
        do_reset();
        out_ready = 1'b1;
        run = 0; best = 0; total = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 10) applyStimulus(32'h5A5A_5A5A, 2'(i), 8'h5A, 1'b0, 2'b11);
            else        in_valid = 1'b0;
            tick();
            if (out_valid && out_hit) begin
                run++;
                total++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        n_cmp++;
        if (best != 10 || total != 10) begin
            n_fail++;
            $display("[TB] FAIL stream_run: got run=%0d total=%0d, expected 10 and 10", best, total);
        end
        n_cmp++;
        if (hit_cnt !== (CNT_EN ? 8'd10 : 8'd0)) begin
            n_fail++;
            $display("[TB] FAIL stream_cnt: got %0d expected %0d", hit_cnt, CNT_EN ? 10 : 0);
        end
    endtask

    task automatic test_reset_midflight();
        logic stale;
        int k;
        do_reset();
        out_ready = 1'b1;
        applyStimulus(32'hFF00_0000, 2'd3, 8'h00, 1'b0, 2'b00);
        tick();
        tick();
        in_valid = 1'b0;
        k = 0;
        while (sb.size() != 0 && k < 20) begin tick(); k++; end
        applyStimulus(32'hFF00_0000, 2'd3, 8'h00, 1'b0, 2'b00);
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        n_cmp++;
        if (out_valid !== 1'b0 || out_hit !== 1'b0 || out_ch !== 2'd0 || hit_cnt !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL midreset_async: got valid=%0b hit=%0b ch=%0d cnt=%0d, expected all zero", out_valid, out_hit, out_ch, hit_cnt);
        end
        tick();
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        n_cmp++;
        if (stale || hit_cnt !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL midreset_stale: stale=%0b cnt=%0d, expected 0 and 0", stale, hit_cnt);
        end
    endtask

    task automatic test_saturate();
        int k;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(32'h1234_5678, 2'd1, 8'h56, 1'b0, 2'b11);
            tick();
        end
        in_valid = 1'b0;
        k = 0;
        while (sb.size() != 0 && k < 20) begin tick(); k++; end
        tick();
        n_cmp++;
        if (sb.size() != 0 || hit_cnt !== (CNT_EN ? 8'd255 : 8'd0)) begin
            n_fail++;
            $display("[TB] FAIL sat_cnt: got cnt=%0d pending=%0d, expected cnt=%0d pending=0", hit_cnt, sb.size(), CNT_EN ? 255 : 0);
        end
    endtask

    initial begin
        $display("[TB] mag_cmp_pipe bench start, counter build=%0b", CNT_EN);
        test_reset();
        test_gt_tiebreak();
        test_signed();
        test_random();
        test_back_to_back();
        test_stream();
        test_reset_midflight();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mag_cmp_pipe.md
MAG_CMP_PIPE -- requirements
Module: mag_cmp_pipe

Interface
REQ-001 Parameter W, default 8: operand width in bits, legal 2..32.
REQ-002 Parameter N_CH, default 4: operand channel count, power of two, legal 2..16.
REQ-003 Parameter SIGNED_CMP, default 0: 1 = two's-complement compare, 0 = unsigned compare.
REQ-004 clk  input  1  sole clock; all flops rise on the posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  input beat is present.
REQ-007 in_ready  output  1  the block accepts the beat this cycle.
REQ-008 ch_data  input  N_CH*W  packed channel operands; channel k occupies bits [k*W +: W].
REQ-009 ch_sel  input  log2(N_CH)  selects the operand A.
REQ-010 thr  input  W  threshold operand B.
REQ-011 cin  input  1  tie-break carry; applied only in GT mode.
REQ-012 cmp_mode  input  2  00 GT, 01 GE, 10 LT, 11 EQ.
REQ-013 out_valid  output  1  result beat is present.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_hit  output  1  compare result.
REQ-016 out_ch  output  log2(N_CH)  ch_sel of the beat that produced the result.
REQ-017 hit_cnt  output  8  saturating count of delivered hits; present only with the macro.

Function
REQ-018 Pipeline: 2 register stages. S1 holds A, B, cin, mode and ch. S2 holds hit and ch and drives the outputs.
REQ-019 Advance enable: en = !out_valid || out_ready. Both stages load on en and hold otherwise.
REQ-020 in_ready = en, combinationally. A beat is accepted when in_valid && in_ready.
REQ-021 Latency: an accepted beat appears on out_valid exactly 2 cycles later, absent stalls.
REQ-022 Bubbles propagate: S1 valid loads in_valid&&en; S2 valid loads S1 valid on en.
REQ-023 GT: hit = (A > B) || (A == B && cin).
REQ-024 GE: hit = A >= B. LT: hit = A < B. EQ: hit = A == B. cin is ignored in these three modes.
REQ-025 Signedness: comparisons use SIGNED_CMP semantics over the full W bits.
REQ-026 While out_valid && !out_ready, out_hit and out_ch stay stable and no beat is lost or duplicated.
REQ-027 Full throughput: with out_ready held 1, one result is delivered every cycle.
REQ-028 An out-of-range ch_sel cannot occur, because N_CH is a power of two.

Reset
REQ-029 On rst_n low, both stage-valid bits clear, out_hit=0, out_ch=0 and hit_cnt=0, asynchronously.
REQ-030 A reset mid-operation discards all in-flight beats.
REQ-031 After reset, in_ready=1 in the first cycle.
REQ-032 Reset release is synchronised to clk by the integrator; the block assumes nothing beyond that.

Configuration
REQ-033 Macro MAG_CMP_HIT_CNT_EN controls the hit counter.
- Defined: hit_cnt increments on each out_valid && out_ready && out_hit cycle, and saturates at 255.
- Undefined: hit_cnt is constant 0 and no counter flops exist.

Verification
REQ-034 W=8, N_CH=4, unsigned, GT. ch2=0x40, thr=0x40, ch_sel=2, cin=1 -> out_hit=1, out_ch=2, 2 cycles after accept.
- Same beat with cin=0 -> out_hit=0.
REQ-035 SIGNED_CMP=1, LT. A=0x80, B=0x01 -> out_hit=1.
- SIGNED_CMP=0, same operands -> out_hit=0.
REQ-036 Back-pressure: 3 beats sent, out_ready low for 4 cycles.
- Required: in_ready=0 once both stages are full, out_hit/out_ch stable while stalled, all 3 results delivered in order after release.
REQ-037 Streaming: out_ready=1 and in_valid=1 for 10 cycles in EQ mode, equal operands -> 10 consecutive out_hit=1.
- With MAG_CMP_HIT_CNT_EN defined: hit_cnt=10.
REQ-038 rst_n pulsed low while 2 beats are in flight -> out_valid=0 immediately, no stale result after release, hit_cnt=0.
REQ-039 With MAG_CMP_HIT_CNT_EN defined, 300 delivered hits -> hit_cnt holds at 255.
